aes_dec_sequencer: RTL and testbench

Round sequencer for the byte-serial AES-128 decryption datapath (byte permutation → inverse S-box → key add → inverse mix-columns → parallel-to-serial). It accepts one 16-byte ciphertext block over a valid/ready byte stream and steps the shared datapath through the initial key add, nine full rounds and the final round, generating key-schedule byte addresses and datapath enables. It then streams the 16 plaintext bytes out under backpressure. The datapath and the 176-byte expanded-key store sit outside this block.

---
 rtl/aes_seq_pkg.sv | 24 ++
 rtl/seq_byte_counter.sv | 28 ++
 rtl/aes_dec_sequencer.sv | 156 +++++++++++++++
 tb/tb_aes_dec_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES-128 decryption round sequencer.
package aes_seq_pkg;

  localparam int NUM_ROUNDS  = 10;
  localparam int BLOCK_BYTES = 16;
  localparam int KEY_BYTES   = 176;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ROUND  = 3'd2,
    DRAIN  = 3'd3,
    OUTPUT = 3'd4
  } seq_state_t;

  // Decryption walks the key schedule backwards: round 0 uses the last
  // 16 key bytes (160..175), round 10 the first 16 (0..15).
  function automatic logic [7:0] key_addr_f(input logic [3:0] rnd, input logic [3:0] idx);
    int a;
    a = KEY_BYTES - BLOCK_BYTES * (int'(rnd) + 1) + int'(idx);
    return 8'(a);
  endfunction

endpackage

// File: rtl/seq_byte_counter.sv
// Mod-16 byte position counter with clear (priority) and enable, plus a
// terminal-count flag at 15. Wrapping from 15 returns to 0 naturally.
module seq_byte_counter (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  output logic [3:0] o_count,
  output logic       o_tc
);

  logic [3:0] r_count;

  // Counter register: clear wins over increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= 4'd0;
    end else if (i_clr) begin
      r_count <= 4'd0;
    end else if (i_en) begin
      r_count <= r_count + 4'd1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == 4'hF);

endmodule

// File: rtl/aes_dec_sequencer.sv
// Round sequencer for the byte-serial AES-128 decryption datapath: loads a
// ciphertext block, steps initial key add + 9 full rounds + final round
// with a drain gap of PIPE_LAT cycles after each, then streams plaintext.
module aes_dec_sequencer
  import aes_seq_pkg::*;
#(
  parameter int PIPE_LAT = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic [3:0] o_round,
  output logic [3:0] o_byte_idx,
  output logic [7:0] o_key_addr,
  output logic       o_din_sel,
  output logic       o_en_dp,
  output logic       o_en_sbox,
  output logic       o_en_mc,
  output logic       o_en_pts
);

  localparam logic [2:0] DRAIN_LAST = 3'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  seq_state_t r_state, w_state_next;
  logic [3:0] r_round, w_round_next;
  logic [2:0] r_drain, w_drain_next;
  logic       r_done,  w_done_next;
  logic       w_cnt_clr, w_cnt_en;
  logic [3:0] w_byte_idx;
  logic       w_byte_last;
  logic       w_in_rounds;

  seq_byte_counter u_byte_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_count (w_byte_idx),
    .o_tc    (w_byte_last)
  );

  // State, round, drain and done registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_round <= 4'd0;
      r_drain <= 3'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_round <= w_round_next;
      r_drain <= w_drain_next;
      r_done  <= w_done_next;
    end
  end

  // Next-state logic; abort overrides every other event.
  always_comb begin
    w_state_next = r_state;
    w_round_next = r_round;
    w_drain_next = r_drain;
    w_done_next  = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_en     = 1'b0;
    if (i_abort) begin
      w_state_next = IDLE;
      w_round_next = 4'd0;
      w_drain_next = 3'd0;
      w_cnt_clr    = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            w_state_next = LOAD;
            w_round_next = 4'd0;
            w_cnt_clr    = 1'b1;
          end
        end
        LOAD: begin
          if (i_in_valid) begin
            w_cnt_en = 1'b1;
            if (w_byte_last) w_state_next = ROUND;
          end
        end
        ROUND: begin
          w_cnt_en = 1'b1;
          if (w_byte_last) begin
            if (PIPE_LAT == 0) begin
              // No pipeline gap: advance the round directly.
              if (r_round == LAST_ROUND) w_state_next = OUTPUT;
              else                       w_round_next = r_round + 4'd1;
            end else begin
              w_state_next = DRAIN;
              w_drain_next = 3'd0;
            end
          end
        end
        DRAIN: begin
          if (r_drain == DRAIN_LAST) begin
            w_drain_next = 3'd0;
            if (r_round == LAST_ROUND) begin
              w_state_next = OUTPUT;
            end else begin
              w_round_next = r_round + 4'd1;
              w_state_next = ROUND;
            end
          end else begin
            w_drain_next = r_drain + 3'd1;
          end
        end
        OUTPUT: begin
          if (i_out_ready) begin
            w_cnt_en = 1'b1;
            if (w_byte_last) begin
              // Counter wraps to 0 on this accept; round is cleared here.
              w_state_next = IDLE;
              w_round_next = 4'd0;
              w_done_next  = 1'b1;
            end
          end
        end
        default: begin
          w_state_next = IDLE;
          w_round_next = 4'd0;
          w_cnt_clr    = 1'b1;
        end
      endcase
    end
  end

  // Datapath controls stay set through DRAIN so in-flight bytes keep
  // seeing the same stage configuration as when they were issued.
  assign w_in_rounds = (r_state == ROUND) || (r_state == DRAIN);

  assign o_in_ready  = (r_state == LOAD);
  assign o_out_valid = (r_state == OUTPUT);
  assign o_en_dp     = (r_state == ROUND);
  assign o_key_addr  = o_en_dp ? key_addr_f(r_round, w_byte_idx) : 8'd0;
  assign o_en_pts    = o_out_valid & i_out_ready;
  assign o_busy      = (r_state != IDLE);
  assign o_done      = r_done;
  assign o_round     = r_round;
  assign o_byte_idx  = w_byte_idx;
  assign o_din_sel   = w_in_rounds && (r_round != 4'd0);
  assign o_en_sbox   = w_in_rounds && (r_round != 4'd0);
  assign o_en_mc     = w_in_rounds && (r_round != 4'd0) && (r_round != LAST_ROUND);

endmodule

// File: tb/tb_aes_dec_sequencer.sv
// Directed + randomized bench for aes_dec_sequencer. The expected behaviour
// is an issue schedule built from the round rules: per round 16 issues of
// key bytes (10-r)*16+b followed by PIPE_LAT idle cycles, bracketed by a
// 16-accept load and a 16-accept output phase.
module tb_aes_dec_sequencer;

  localparam int PL = 2;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, in_valid, out_ready;
  logic       in_ready, out_valid, busy, done, din_sel, en_dp, en_sbox, en_mc, en_pts;
  logic [3:0] round, byte_idx;
  logic [7:0] key_addr;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  aes_dec_sequencer #(.PIPE_LAT(PL)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_abort     (abort),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_busy      (busy),
    .o_done      (done),
    .o_round     (round),
    .o_byte_idx  (byte_idx),
    .o_key_addr  (key_addr),
    .o_din_sel   (din_sel),
    .o_en_dp     (en_dp),
    .o_en_sbox   (en_sbox),
    .o_en_mc     (en_mc),
    .o_en_pts    (en_pts)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'(0));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    chk({tag, "_busy"},      32'(busy),      32'(0));
    chk({tag, "_done"},      32'(done),      32'(0));
    chk({tag, "_round"},     32'(round),     32'(0));
    chk({tag, "_byte_idx"},  32'(byte_idx),  32'(0));
    chk({tag, "_key_addr"},  32'(key_addr),  32'(0));
    chk({tag, "_din_sel"},   32'(din_sel),   32'(0));
    chk({tag, "_en_dp"},     32'(en_dp),     32'(0));
    chk({tag, "_en_sbox"},   32'(en_sbox),   32'(0));
    chk({tag, "_en_mc"},     32'(en_mc),     32'(0));
    chk({tag, "_en_pts"},    32'(en_pts),    32'(0));
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // in_mode/out_mode: 0 = always asserted, 1 = toggle 1/0, 2 = random.
  task automatic run_block(input string name, input int in_mode, input int out_mode,
                           input bit noise, input int stall_at, input int stall_len,
                           input int abort_r, input int abort_b, input int rst_at);
    int acc, istall, ostall, first, scnt, guard, span;
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
    #1;
    chk("start_busy", 32'(busy), 32'(0));
    chk("start_in_ready", 32'(in_ready), 32'(0));

    // Load phase: 16 accepts, counter tracks accepts, stalls hold it.
    acc = 0; istall = 0; first = 0; guard = 0;
    while (acc < 16 && guard < 400) begin
      @(negedge clk);
      start = noise ? rbit() : 1'b0;
      case (in_mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (guard % 2 == 0);
        default: in_valid = rbit();
      endcase
      #1;
      chk("load_in_ready", 32'(in_ready), 32'(1));
      chk("load_byte_idx", 32'(byte_idx), 32'(acc));
      chk("load_round", 32'(round), 32'(0));
      chk("load_din_sel", 32'(din_sel), 32'(0));
      chk("load_en_dp", 32'(en_dp), 32'(0));
      if (in_valid) begin
        if (acc == 0) first = cyc;
        acc++;
      end else if (acc > 0) begin
        istall++;
      end
      guard++;
    end
    chk("load_accepts", 32'(acc), 32'(16));

    // Round schedule: 11 rounds of 16 issues + PL drain cycles.
    for (int r = 0; r <= 10; r++) begin
      for (int k = 0; k < 16 + PL; k++) begin
        @(negedge clk);
        start = noise ? rbit() : 1'b0;
        in_valid = noise ? rbit() : 1'b0;
        out_ready = noise ? rbit() : 1'b0;
        abort = (r == abort_r && k == abort_b);
        #1;
        chk("rnd_round", 32'(round), 32'(r));
        chk("rnd_in_ready", 32'(in_ready), 32'(0));
        chk("rnd_out_valid", 32'(out_valid), 32'(0));
        chk("rnd_busy", 32'(busy), 32'(1));
        if (k < 16) begin
          chk("rnd_en_dp", 32'(en_dp), 32'(1));
          chk("rnd_byte_idx", 32'(byte_idx), 32'(k));
          chk("rnd_key_addr", 32'(key_addr), 32'((10 - r) * 16 + k));
          chk("rnd_en_sbox", 32'(en_sbox), 32'(r != 0));
          chk("rnd_en_mc", 32'(en_mc), 32'(r >= 1 && r <= 9));
          chk("rnd_din_sel", 32'(din_sel), 32'(r != 0));
        end else begin
          chk("drain_en_dp", 32'(en_dp), 32'(0));
        end
        if (abort) begin
          @(negedge clk);
          abort = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
          #1;
          check_all_zero("abort");
          for (int w = 0; w < 20; w++) begin
            @(negedge clk); #1;
            chk("abort_no_done", 32'(done), 32'(0));
          end
          $display("block %s: aborted at round %0d byte %0d", name, r, k);
          return;
        end
      end
    end

    // Output phase: 16 accepts under backpressure.
    acc = 0; ostall = 0; scnt = 0; guard = 0;
    while (acc < 16 && guard < 400) begin
      @(negedge clk);
      start = noise ? rbit() : 1'b0;
      in_valid = noise ? rbit() : 1'b0;
      if (acc == stall_at && scnt < stall_len) begin
        out_ready = 1'b0;
        scnt++;
      end else begin
        case (out_mode)
          0:       out_ready = 1'b1;
          1:       out_ready = (guard % 2 == 0);
          default: out_ready = rbit();
        endcase
      end
      if (acc == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid_out");
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check_all_zero("rst_release");
        $display("block %s: reset at output byte %0d", name, acc);
        return;
      end
      #1;
      chk("out_valid", 32'(out_valid), 32'(1));
      chk("out_byte_idx", 32'(byte_idx), 32'(acc));
      chk("out_en_pts", 32'(en_pts), 32'(out_ready));
      chk("out_round", 32'(round), 32'(10));
      chk("out_done", 32'(done), 32'(0));
      chk("out_busy", 32'(busy), 32'(1));
      chk("out_en_dp", 32'(en_dp), 32'(0));
      if (out_ready) acc++;
      else           ostall++;
      guard++;
    end
    chk("out_accepts", 32'(acc), 32'(16));

    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("done_pulse", 32'(done), 32'(1));
    chk("done_busy", 32'(busy), 32'(0));
    chk("done_round", 32'(round), 32'(0));
    chk("done_byte_idx", 32'(byte_idx), 32'(0));
    chk("done_out_valid", 32'(out_valid), 32'(0));
    // Cycles counted inclusively from the first-accept cycle to the done cycle.
    span = cyc - first + 1;
    chk("latency", 32'(span), 32'(16 + 11 * (16 + PL) + 16 + 1 + istall + ostall));
    @(negedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'(0));
    $display("block %s: %0d cycles first accept..done, %0d in stalls, %0d out stalls",
             name, span, istall, ostall);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_all_zero("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check_all_zero("idle");
    end

    run_block("nominal",     0, 0, 1'b0, -1, 0, -1, -1, -1);
    run_block("in_toggle",   1, 0, 1'b0, -1, 0, -1, -1, -1);
    run_block("out_stall7",  0, 0, 1'b0,  7, 3, -1, -1, -1);
    run_block("abort_r5b9",  0, 0, 1'b0, -1, 0,  5,  9, -1);
    run_block("after_abort", 0, 0, 1'b0, -1, 0, -1, -1, -1);
    run_block("random_a",    2, 2, 1'b1, -1, 0, -1, -1, -1);
    run_block("random_b",    2, 1, 1'b1, $urandom_range(0, 15), $urandom_range(1, 4), -1, -1, -1);
    run_block("rst_mid_out", 0, 0, 1'b0, -1, 0, -1, -1,  8);
    run_block("after_rst",   2, 2, 1'b1, -1, 0, -1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
